// File: rtl/gshare_predictor.sv
// gshare_predictor: 2-bit saturating-counter branch predictor indexed by
// PC xor history. MODE=0 uses one speculative global history register,
// MODE=1 uses a per-PC local history table.
// Both tables are swept to their initial values after every reset release.
// Ports:
//   clk, reset (async, active-low)
//   ready                               - high once the init sweep is done
//   lookup_valid, lookup_pc             - prediction request
//   pred_valid, pred_taken,
//   pred_index, pred_hist               - registered prediction result
//   update_valid, update_pc,
//   update_index, update_hist,
//   update_taken, update_mispredict     - resolved-branch training request
module gshare_predictor #(
  parameter int unsigned PC_W   = 6,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned HIST_W = 6,
  parameter int unsigned MODE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  input  logic              lookup_valid,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_index,
  output logic [HIST_W-1:0] pred_hist,
  input  logic              update_valid,
  input  logic [PC_W-1:0]   update_pc,
  input  logic [IDX_W-1:0]  update_index,
  input  logic [HIST_W-1:0] update_hist,
  input  logic              update_taken,
  input  logic              update_mispredict
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_init_cnt;
  logic [HIST_W-1:0]   r_ghr;
  logic [1:0]          r_ctr [DEPTH];

  logic                w_run;
  logic                w_lookup_acc;
  logic                w_update_acc;
  logic [IDX_W-1:0]    w_lookup_idx;
  logic [IDX_W-1:0]    w_update_pc_idx;
  logic [HIST_W-1:0]   w_hist;
  logic [HIST_W-1:0]   w_ghr_next;
  logic [IDX_W-1:0]    w_index;
  logic [1:0]          w_ctr_rd;
  logic                w_pred;
  logic [1:0]          w_ctr_old;
  logic [1:0]          w_ctr_next;
  logic                w_unused;

  // Requests are only honoured once the init sweep has finished
  assign w_run           = (r_state == ST_RUN);
  assign w_lookup_acc    = w_run & lookup_valid;
  assign w_update_acc    = w_run & update_valid;
  assign w_lookup_idx    = lookup_pc[IDX_W-1:0];
  assign w_update_pc_idx = update_pc[IDX_W-1:0];

  // Index hashing and counter read (pre-edge value, no update bypass)
  assign w_index  = w_lookup_idx ^ IDX_W'(w_hist);
  assign w_ctr_rd = r_ctr[w_index];
  assign w_pred   = w_ctr_rd[1];

  // Saturating counter training
  assign w_ctr_old  = r_ctr[update_index];
  assign w_ctr_next = update_taken ? ((w_ctr_old == 2'd3) ? 2'd3 : w_ctr_old + 2'd1)
                                   : ((w_ctr_old == 2'd0) ? 2'd0 : w_ctr_old - 2'd1);

  // Some request fields are meaningful in only one MODE
  assign w_unused = ^{lookup_pc, update_pc, update_hist, update_mispredict};

  generate
    if (MODE == 0) begin : g_global
      assign w_hist = r_ghr;
      // Mispredict recovery takes priority over the speculative shift
      assign w_ghr_next = (w_update_acc & update_mispredict) ? {update_hist[HIST_W-2:0], update_taken}
                        : w_lookup_acc                      ? {r_ghr[HIST_W-2:0], w_pred}
                        :                                     r_ghr;
    end else begin : g_local
      logic [HIST_W-1:0] r_lht [DEPTH];

      assign w_hist     = r_lht[w_lookup_idx];
      assign w_ghr_next = r_ghr;

      // Local history table: RAM-style, no reset
      always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
          r_lht[r_init_cnt] <= '0;
        end else if (w_update_acc) begin
          r_lht[w_update_pc_idx] <= {r_lht[w_update_pc_idx][HIST_W-2:0], update_taken};
        end
      end
    end
  endgenerate

  // Counter table: RAM-style, no reset
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_ctr[r_init_cnt] <= 2'b01;
    end else if (w_update_acc) begin
      r_ctr[update_index] <= w_ctr_next;
    end
  end

  // Init/run FSM, global history and registered prediction outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_ghr      <= '0;
      ready      <= 1'b0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_index <= '0;
      pred_hist  <= '0;
    end else begin
      pred_valid <= 1'b0;
      case (r_state)
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + IDX_W'(1);
          if (&r_init_cnt) begin
            r_state <= ST_RUN;
            ready   <= 1'b1;
          end
        end
        ST_RUN: begin
          r_ghr <= w_ghr_next;
          if (w_lookup_acc) begin
            pred_valid <= 1'b1;
            pred_taken <= w_pred;
            pred_index <= w_index;
            pred_hist  <= w_hist;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: a global-history (MODE=0) and a local-history
// (MODE=1) instance share one stimulus stream and are compared every cycle
// against an array-based behavioural model, plus directed scenario checks.
module tb_gshare_predictor;

  localparam int unsigned PC_W   = 6;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned HIST_W = 6;
  localparam int unsigned DEPTH  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              lookup_valid;
  logic [PC_W-1:0]   lookup_pc;
  logic              update_valid;
  logic [PC_W-1:0]   update_pc;
  logic [IDX_W-1:0]  update_index;
  logic [HIST_W-1:0] update_hist;
  logic              update_taken;
  logic              update_mispredict;

  logic              ready0, pv0, pt0;
  logic [IDX_W-1:0]  pidx0;
  logic [HIST_W-1:0] phist0;
  logic              ready1, pv1, pt1;
  logic [IDX_W-1:0]  pidx1;
  logic [HIST_W-1:0] phist1;

  gshare_predictor #(.PC_W(PC_W), .IDX_W(IDX_W), .HIST_W(HIST_W), .MODE(0)) u_dut_g (
    .clk(clk), .reset(reset), .ready(ready0),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pv0), .pred_taken(pt0), .pred_index(pidx0), .pred_hist(phist0),
    .update_valid(update_valid), .update_pc(update_pc), .update_index(update_index),
    .update_hist(update_hist), .update_taken(update_taken),
    .update_mispredict(update_mispredict)
  );

  gshare_predictor #(.PC_W(PC_W), .IDX_W(IDX_W), .HIST_W(HIST_W), .MODE(1)) u_dut_l (
    .clk(clk), .reset(reset), .ready(ready1),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pv1), .pred_taken(pt1), .pred_index(pidx1), .pred_hist(phist1),
    .update_valid(update_valid), .update_pc(update_pc), .update_index(update_index),
    .update_hist(update_hist), .update_taken(update_taken),
    .update_mispredict(update_mispredict)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  int  m_ctr0 [DEPTH];
  int  m_ctr1 [DEPTH];
  int  m_lht  [DEPTH];
  int  m_ghr;
  bit  m_ready;
  int  m_init;
  int  e_pv [2];
  int  e_pt [2];
  int  e_pidx [2];
  int  e_phist [2];

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int c, input bit taken);
    if (taken) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  // Advance the model by one rising edge using the current inputs
  task automatic model_step();
    int h0, h1, i0, i1, p0, p1;
    if (!reset) return;
    e_pv[0] = 0;
    e_pv[1] = 0;
    if (!m_ready) begin
      m_init++;
      if (m_init == DEPTH) begin
        m_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
          m_ctr0[i] = 1;
          m_ctr1[i] = 1;
          m_lht[i]  = 0;
        end
      end
      return;
    end
    if (lookup_valid) begin
      h0 = m_ghr;
      h1 = m_lht[lookup_pc];
      i0 = int'(lookup_pc) ^ h0;
      i1 = int'(lookup_pc) ^ h1;
      p0 = m_ctr0[i0] / 2;
      p1 = m_ctr1[i1] / 2;
      e_pv[0] = 1; e_pt[0] = p0; e_pidx[0] = i0; e_phist[0] = h0;
      e_pv[1] = 1; e_pt[1] = p1; e_pidx[1] = i1; e_phist[1] = h1;
    end
    if (update_valid) begin
      m_ctr0[update_index] = sat(m_ctr0[update_index], update_taken);
      m_ctr1[update_index] = sat(m_ctr1[update_index], update_taken);
      m_lht[update_pc] = ((m_lht[update_pc] * 2) + int'(update_taken)) % DEPTH;
    end
    if (update_valid && update_mispredict)
      m_ghr = ((int'(update_hist) * 2) + int'(update_taken)) % DEPTH;
    else if (lookup_valid)
      m_ghr = ((m_ghr * 2) + p0) % DEPTH;
  endtask

  task automatic check_outputs();
    chk("ready_g", ready0, m_ready);
    chk("ready_l", ready1, m_ready);
    chk("pv_g", pv0, e_pv[0]);
    chk("pv_l", pv1, e_pv[1]);
    chk("pt_g", pt0, e_pt[0]);
    chk("pt_l", pt1, e_pt[1]);
    chk("pidx_g", pidx0, e_pidx[0]);
    chk("pidx_l", pidx1, e_pidx[1]);
    chk("phist_g", phist0, e_phist[0]);
    chk("phist_l", phist1, e_phist[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    lookup_valid = 1'b0;
    update_valid = 1'b0;
  endtask

  // Assert reset between edges, check the asynchronous effect, hold, release
  task automatic apply_reset();
    reset = 1'b0;
    m_ready = 0;
    m_init  = 0;
    m_ghr   = 0;
    for (int k = 0; k < 2; k++) begin
      e_pv[k] = 0; e_pt[k] = 0; e_pidx[k] = 0; e_phist[k] = 0;
    end
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    for (int i = 1; i <= 200 && n == 0; i++) begin
      cycle();
      if (ready0 === 1'b1) n = i;
    end
    chk("init_len", n, DEPTH);
  endtask

  task automatic do_lookup(input int pc);
    lookup_valid = 1'b1;
    lookup_pc    = PC_W'(pc);
    cycle();
  endtask

  task automatic do_update(input int pc, input int idx, input int hist,
                           input bit taken, input bit misp);
    update_valid      = 1'b1;
    update_pc         = PC_W'(pc);
    update_index      = IDX_W'(idx);
    update_hist       = HIST_W'(hist);
    update_taken      = taken;
    update_mispredict = misp;
    cycle();
  endtask

  initial begin
    reset = 1'b1;
    lookup_valid = 1'b0; lookup_pc = '0;
    update_valid = 1'b0; update_pc = '0; update_index = '0;
    update_hist = '0; update_taken = 1'b0; update_mispredict = 1'b0;
    #2;

    // Reset release, init length, first lookup
    apply_reset();
    wait_ready();
    do_lookup(5);
    chk("r26_pv", pv0, 1);
    chk("r26_pt", pt0, 0);
    chk("r26_idx", pidx0, 5);
    chk("r26_hist", phist0, 0);

    // Counter saturation up then down at index 9
    apply_reset();
    wait_ready();
    for (int i = 0; i < 3; i++) do_update(9, 9, 0, 1'b1, 1'b0);
    do_lookup(9);
    chk("r27_idx_up", pidx0, 9);
    chk("r27_pt_up", pt0, 1);
    for (int i = 0; i < 4; i++) do_update(9, 9, 0, 1'b0, 1'b0);
    do_lookup(8);  // GHR is now 000001, so pc 8 hashes to index 9
    chk("r27_idx_dn", pidx0, 9);
    chk("r27_pt_dn", pt0, 0);

    // Speculative GHR shift changes the next index
    apply_reset();
    wait_ready();
    do_update(3, 3, 0, 1'b1, 1'b0);
    do_update(3, 3, 0, 1'b1, 1'b0);
    do_lookup(3);
    chk("r28_idx1", pidx0, 3);
    chk("r28_pt1", pt0, 1);
    do_lookup(3);
    chk("r28_idx2", pidx0, 2);
    chk("r28_hist2", phist0, 1);

    // Mispredict recovery overrides same-cycle speculative shift
    apply_reset();
    wait_ready();
    lookup_valid = 1'b1;
    lookup_pc    = PC_W'(7);
    do_update(12, 20, 5, 1'b1, 1'b1);
    do_lookup(0);
    chk("r29_hist", phist0, 11);
    chk("r29_idx", pidx0, 11);

    // Local history build-up
    apply_reset();
    wait_ready();
    do_update(4, 4, 0, 1'b1, 1'b0);
    do_update(4, 4, 0, 1'b1, 1'b0);
    do_lookup(4);
    chk("r30_idx", pidx1, 7);
    chk("r30_hist", phist1, 3);

    // Reset mid-INIT and mid-RUN
    apply_reset();
    repeat (30) cycle();
    apply_reset();
    chk("r31_rdy_init", ready0, 0);
    wait_ready();
    do_lookup(6);
    chk("r31_pv_pre", pv0, 1);
    apply_reset();
    chk("r31_pv_run", pv0, 0);
    chk("r31_rdy_run", ready0, 0);
    wait_ready();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      lookup_valid      = 1'($urandom_range(0, 1));
      lookup_pc         = PC_W'($urandom);
      update_valid      = 1'($urandom_range(0, 1));
      update_pc         = PC_W'($urandom);
      update_index      = ($urandom_range(0, 1) == 0) ? IDX_W'(lookup_pc) : IDX_W'($urandom);
      update_hist       = HIST_W'($urandom);
      update_taken      = 1'($urandom_range(0, 1));
      update_mispredict = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
